// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: loader FSM state encoding and frame helpers shared by the loader files.
package mem_loader_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] LAST_BYTE = 2'd3;

    function automatic logic receiving(input state_t s);
        return s inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHK};
    endfunction
endpackage

// File: rtl/mem_loader_timeout.sv
// mem_loader_timeout: counts idle receive cycles and pulses expire on the TIMEOUT_CYC-th one.
module mem_loader_timeout #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT_CYC + 1);

    logic [W-1:0] cnt;

    assign expire = enable & ~clear & (cnt == W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear || !enable)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/mem_loader.sv
// mem_loader: framed big-endian byte stream to sequential 32-bit memory writes,
// holding the CPU stalled until a frame with a good XOR checksum completes.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          MAX_WORDS   = 256,
    parameter int          TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] word_count
);
    state_t      state, state_nx;
    logic        start_q, start_rise, hs, expire, last_word;
    logic [15:0] len, len_n, rcv_cnt;
    logic [23:0] acc;
    logic [7:0]  chk;
    logic [1:0]  byte_idx;

    assign rx_ready   = receiving(state);
    assign hs         = rx_valid & rx_ready;
    assign start_rise = load_start & ~start_q & ~rx_ready;
    assign len_n      = {len[15:8], rx_data};
    assign last_word  = (rcv_cnt + 16'd1) == len;

    mem_loader_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (hs | ~rx_ready),
        .enable (rx_ready),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: state_nx = start_rise ? S_LEN_HI : state;
            S_LEN_HI: state_nx = hs ? S_LEN_LO : state;
            S_LEN_LO: if (hs) state_nx = (32'(len_n) > MAX_WORDS) ? S_ERR :
                                         (len_n == 16'd0) ? S_CHK : S_DATA;
            S_DATA:   state_nx = (hs && byte_idx == LAST_BYTE && last_word) ? S_CHK : state;
            S_CHK:    if (hs) state_nx = (rx_data == chk) ? S_DONE : S_ERR;
            default:  state_nx = S_IDLE;
        endcase
        if (expire)
            state_nx = S_ERR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            word_count <= '0;
            len        <= '0;
            rcv_cnt    <= '0;
            acc        <= '0;
            chk        <= '0;
            byte_idx   <= '0;
        end else begin
            start_q <= load_start;
            mem_we  <= 1'b0;
            // address and count advance once the strobe has been presented
            if (mem_we) begin
                mem_addr   <= mem_addr + 32'd4;
                word_count <= word_count + 16'd1;
            end
            if (hs) begin
                if (state != S_CHK)
                    chk <= chk ^ rx_data;
                if (state == S_LEN_HI)
                    len[15:8] <= rx_data;
                if (state == S_LEN_LO)
                    len[7:0] <= rx_data;
                if (state == S_DATA) begin
                    acc      <= {acc[15:0], rx_data};
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == LAST_BYTE) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= {acc, rx_data};
                        rcv_cnt   <= rcv_cnt + 16'd1;
                    end
                end
            end
            if (start_rise) begin
                load_done  <= 1'b0;
                load_err   <= 1'b0;
                word_count <= '0;
                chk        <= '0;
                mem_addr   <= BASE_ADDR;
                cpu_hold   <= 1'b1;
                rcv_cnt    <= '0;
                byte_idx   <= '0;
            end
            if (state != S_DONE && state_nx == S_DONE) begin
                load_done <= 1'b1;
                cpu_hold  <= 1'b0;
            end
            if (state != S_ERR && state_nx == S_ERR)
                load_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: scoreboard bench; expected writes are queued as bytes are sent and
// popped by a monitor on every mem_we strobe.
module tb_mem_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, mem_we, cpu_hold, load_done, load_err;
    logic [31:0] mem_addr, mem_wdata;
    logic [15:0] word_count;

    int          checks = 0;
    int          passed = 0;
    int          we_cnt = 0;
    logic [63:0] exp_q[$];
    logic [63:0] e;
    logic [31:0] tx_words[$];

    mem_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(256), .TIMEOUT_CYC(100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1) begin
            we_cnt++;
            checks++;
            if (exp_q.size() == 0)
                $display("FAIL wr_unexpected got addr %h data %h, none expected", mem_addr, mem_wdata);
            else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e)
                    $display("FAIL wr_data got addr %h data %h exp addr %h data %h",
                             mem_addr, mem_wdata, e[63:32], e[31:0]);
                else
                    passed++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (rx_ready !== 1'b1 && t < 50) begin
            tick(1);
            t++;
        end
        if (rx_ready !== 1'b1) begin
            checks++;
            $display("FAIL rx_ready_wait got %b exp 1 after %0d cycles", rx_ready, t);
        end
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick(1);
        load_start = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit bad, input int max_gap, input bit poke);
        logic [15:0] len;
        logic [7:0]  c;
        logic [31:0] w;
        len = n[15:0];
        c = len[15:8] ^ len[7:0];
        pulse_start();
        send_byte(len[15:8]);
        send_byte(len[7:0]);
        for (int i = 0; i < n; i++) begin
            w = tx_words[i];
            if (poke)
                load_start = (i == n / 2);
            for (int b = 3; b >= 0; b--) begin
                tick(int'($urandom_range(0, max_gap)));
                send_byte(w[8*b +: 8]);
                c ^= w[8*b +: 8];
            end
            exp_q.push_back({32'(4 * i), w});
        end
        load_start = 1'b0;
        checks++;
        if (cpu_hold !== 1'b1) $display("FAIL hold_before_chk got %b exp 1", cpu_hold); else passed++;
        send_byte(bad ? (c ^ 8'h01) : c);
        tick(1);
    endtask

    task automatic test_reset();
        tick(3);
        checks++;
        if ({rx_ready, mem_we, cpu_hold, load_done, load_err} !== 5'b0 || mem_addr !== 32'h0 ||
            mem_wdata !== 32'h0 || word_count !== 16'h0)
            $display("FAIL reset_outputs got rdy%b we%b hold%b done%b err%b addr%h wd%h wc%h exp all 0",
                     rx_ready, mem_we, cpu_hold, load_done, load_err, mem_addr, mem_wdata, word_count);
        else passed++;
        rst_n = 1'b1;
        tick(2);
        checks++;
        if (rx_ready !== 1'b0 || cpu_hold !== 1'b0) $display("FAIL idle_after_reset got rdy%b hold%b exp 0 0", rx_ready, cpu_hold); else passed++;
    endtask

    task automatic test_good_frame();
        tx_words.delete();
        tx_words.push_back(32'h1234_5678);
        tx_words.push_back(32'h9ABC_DEF0);
        send_frame(2, 1'b0, 0, 1'b0);
        checks++;
        if (load_done !== 1'b1) $display("FAIL good_done got %b exp 1", load_done); else passed++;
        checks++;
        if (load_err !== 1'b0) $display("FAIL good_err got %b exp 0", load_err); else passed++;
        checks++;
        if (word_count !== 16'd2) $display("FAIL good_word_count got %0d exp 2", word_count); else passed++;
        checks++;
        if (cpu_hold !== 1'b0) $display("FAIL good_hold got %b exp 0", cpu_hold); else passed++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL good_pending got %0d exp 0", exp_q.size()); else passed++;
    endtask

    task automatic test_bad_chk();
        send_frame(2, 1'b1, 1, 1'b0);
        checks++;
        if (load_err !== 1'b1) $display("FAIL badchk_err got %b exp 1", load_err); else passed++;
        checks++;
        if (load_done !== 1'b0) $display("FAIL badchk_done got %b exp 0", load_done); else passed++;
        checks++;
        if (cpu_hold !== 1'b1) $display("FAIL badchk_hold got %b exp 1", cpu_hold); else passed++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL badchk_pending got %0d exp 0", exp_q.size()); else passed++;
    endtask

    task automatic test_len_err();
        int w0;
        w0 = we_cnt;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        checks++;
        if (load_err !== 1'b1 || rx_ready !== 1'b0) $display("FAIL len_err got err%b rdy%b exp 1 0", load_err, rx_ready); else passed++;
        tick(5);
        checks++;
        if (we_cnt != w0) $display("FAIL len_no_write got %0d writes exp 0", we_cnt - w0); else passed++;
    endtask

    task automatic test_timeout();
        int w0;
        w0 = we_cnt;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        tick(50);
        checks++;
        if (load_err !== 1'b0 || rx_ready !== 1'b1) $display("FAIL tmo_early got err%b rdy%b exp 0 1", load_err, rx_ready); else passed++;
        tick(60);
        checks++;
        if (load_err !== 1'b1 || rx_ready !== 1'b0) $display("FAIL tmo_err got err%b rdy%b exp 1 0", load_err, rx_ready); else passed++;
        checks++;
        if (we_cnt != w0 || cpu_hold !== 1'b1) $display("FAIL tmo_state got writes %0d hold%b exp 0 1", we_cnt - w0, cpu_hold); else passed++;
    endtask

    task automatic test_back_to_back();
        tx_words.delete();
        for (int i = 0; i < 256; i++)
            tx_words.push_back($urandom);
        send_frame(256, 1'b0, 1, 1'b1);
        checks++;
        if (load_done !== 1'b1 || load_err !== 1'b0) $display("FAIL max_done got done%b err%b exp 1 0", load_done, load_err); else passed++;
        checks++;
        if (word_count !== 16'd256) $display("FAIL max_word_count got %0d exp 256", word_count); else passed++;
        checks++;
        if (mem_addr !== 32'h400) $display("FAIL max_addr_end got %h exp 00000400", mem_addr); else passed++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL max_pending got %0d exp 0", exp_q.size()); else passed++;
        tx_words.delete();
        tx_words.push_back(32'hCAFE_F00D);
        tx_words.push_back(32'h0BAD_BEEF);
        send_frame(2, 1'b0, 0, 1'b0);
        checks++;
        if (load_done !== 1'b1 || word_count !== 16'd2) $display("FAIL restart got done%b wc%0d exp 1 2", load_done, word_count); else passed++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL restart_pending got %0d exp 0", exp_q.size()); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        w = 32'hA5C3_0F96;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h04);
        for (int b = 3; b >= 0; b--)
            send_byte(w[8*b +: 8]);
        exp_q.push_back({32'h0, w});
        send_byte(8'h11);
        send_byte(8'h22);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rx_ready, mem_we, cpu_hold, load_done, load_err} !== 5'b0 || mem_addr !== 32'h0 ||
            mem_wdata !== 32'h0 || word_count !== 16'h0)
            $display("FAIL mid_reset got rdy%b we%b hold%b done%b err%b addr%h wd%h wc%h exp all 0",
                     rx_ready, mem_we, cpu_hold, load_done, load_err, mem_addr, mem_wdata, word_count);
        else passed++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL mid_pending got %0d exp 0", exp_q.size()); else passed++;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        tx_words.delete();
        tx_words.push_back(32'h0000_0001);
        send_frame(1, 1'b0, 1, 1'b0);
        checks++;
        if (load_done !== 1'b1 || word_count !== 16'd1 || cpu_hold !== 1'b0)
            $display("FAIL post_reset_frame got done%b wc%0d hold%b exp 1 1 0", load_done, word_count, cpu_hold);
        else passed++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL post_reset_pending got %0d exp 0", exp_q.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_len_err();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        tick(5);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
